// File: rtl/port_uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | port_uart_pkg                                                              |
// | Shared state encoding and register bit positions for the port UART.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package port_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_ACK_BIT  = 1;
    localparam int CTRL_REQ_BIT    = 0;

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_bit_timer                                                             |
// | Counts CLKS_PER_BIT enabled cycles and pulses bit_done on the last one.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_bit_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_tick_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_tick_cnt <= '0;
        end else if (i_enable) begin
            if (r_tick_cnt == C_LAST) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
        end
    end

    // Combinational so the consumer's state change lands exactly on the C-th edge.
    assign o_bit_done = i_enable && (r_tick_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/port_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | port_uart_tx                                                               |
// | 8N1 serial transmitter driven by a toggle request from a CPU output port.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module port_uart_tx
    import port_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_port,
    input  logic [7:0] ctrl_port,
    output logic [7:0] status,
    output logic       tx
);

    uart_state_t r_state, w_state;
    logic        r_req, w_req;
    logic        r_ack, w_ack;
    logic [7:0]  r_shift, w_shift;
    logic [2:0]  r_bit_idx, w_bit_idx;
    logic        r_tx, w_tx;
    logic        w_start_frame;
    logic        w_bit_done;
    logic        w_ctrl_unused;

    assign w_ctrl_unused = ^ctrl_port[7:1];

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_start_frame),
        .i_enable   (r_state != ST_IDLE),
        .o_bit_done (w_bit_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_req     <= 1'b0;
            r_ack     <= 1'b0;
            r_shift   <= 8'h00;
            r_bit_idx <= 3'd0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state;
            r_req     <= w_req;
            r_ack     <= w_ack;
            r_shift   <= w_shift;
            r_bit_idx <= w_bit_idx;
            r_tx      <= w_tx;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_req         = r_req;
        w_ack         = r_ack;
        w_shift       = r_shift;
        w_bit_idx     = r_bit_idx;
        w_tx          = r_tx;
        w_start_frame = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A toggle made while busy stays visible here as a mismatch until IDLE.
                if (ctrl_port[CTRL_REQ_BIT] != r_req) begin
                    w_start_frame = 1'b1;
                    w_shift       = data_port;
                    w_req         = ctrl_port[CTRL_REQ_BIT];
                    w_tx          = 1'b0;
                    w_state       = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    w_state   = ST_DATA;
                    w_bit_idx = 3'd0;
                    w_tx      = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    w_shift = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state = ST_STOP;
                        w_tx    = 1'b1;
                    end else begin
                        w_bit_idx = r_bit_idx + 3'd1;
                        w_tx      = r_shift[1];
                    end
                end
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    w_ack   = r_req;
                    w_state = ST_IDLE;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_tx    = 1'b1;
            end
        endcase
    end

    always_comb begin
        status                  = 8'h00;
        status[STATUS_BUSY_BIT] = (r_state != ST_IDLE);
        status[STATUS_ACK_BIT]  = r_ack;
    end

    assign tx = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_port_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_port_uart_tx                                                            |
// | Directed self-checking bench for port_uart_tx with CLKS_PER_BIT = 4.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_port_uart_tx;

    localparam int C = 4;

    logic       clk;
    logic       reset;
    logic [7:0] data_port;
    logic [7:0] ctrl_port;
    logic [7:0] status;
    logic       tx;

    int n_cmp = 0;
    int n_err = 0;

    port_uart_tx #(
        .CLKS_PER_BIT (C)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_port (data_port),
        .ctrl_port (ctrl_port),
        .status    (status),
        .tx        (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Called just after the request edge E0; leaves the bench just after E0+10C.
    task automatic run_frame(input logic [7:0] d, input logic old_ack, input logic new_ack,
                             input int tog_a, input int tog_b, input logic [7:0] tog_data,
                             input bit scramble);
        logic [9:0] fr;
        fr = {1'b1, d, 1'b0};
        for (int j = 0; j < 10 * C; j++) begin
            chk("frame_tx", {7'b0, tx}, {7'b0, fr[j / C]});
            chk("frame_status", status, {6'b0, old_ack, 1'b1});
            if (j == tog_a || j == tog_b) begin
                ctrl_port = ctrl_port ^ 8'h01;
                data_port = tog_data;
            end
            if (scramble) data_port = 8'($urandom_range(0, 255));
            step();
        end
        chk("end_tx", {7'b0, tx}, 8'h01);
        chk("end_status", status, {6'b0, new_ack, 1'b0});
    endtask

    initial begin
        // Reset held with a request already pending on ctrl.
        reset     = 1'b1;
        ctrl_port = 8'h01;
        data_port = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_tx", {7'b0, tx}, 8'h01);
            chk("rst_status", status, 8'h00);
        end
        reset = 1'b0;
        step();

        // Frame 0xA5 with a second toggle (data 0x3C) pending mid-frame.
        run_frame(8'hA5, 1'b0, 1'b1, 10, -1, 8'h3C, 1'b0);
        step();
        run_frame(8'h3C, 1'b1, 1'b0, -1, -1, 8'h00, 1'b0);

        // Two toggles during one frame cancel out.
        ctrl_port = 8'h01;
        data_port = 8'h0F;
        step();
        run_frame(8'h0F, 1'b0, 1'b1, 5, 20, 8'h99, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("cancel_tx", {7'b0, tx}, 8'h01);
            chk("cancel_status", status, 8'h02);
        end

        // All-ones frame while data_port churns every cycle.
        ctrl_port = 8'h00;
        data_port = 8'hFF;
        step();
        run_frame(8'hFF, 1'b1, 1'b0, -1, -1, 8'h00, 1'b1);

        // Reset lands on E0+15 of a frame; nothing follows with ctrl[0] = 0.
        ctrl_port = 8'h01;
        data_port = 8'h00;
        step();
        chk("mid_busy", status, 8'h01);
        for (int i = 0; i < 14; i++) step();
        reset     = 1'b1;
        ctrl_port = 8'h00;
        step();
        chk("midrst_tx", {7'b0, tx}, 8'h01);
        chk("midrst_status", status, 8'h00);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("post_tx", {7'b0, tx}, 8'h01);
            chk("post_status", status, 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
